// File: rtl/restoring_divider_4_bit_pkg.sv
// Shared definitions for the restoring divider: controller state encoding
// and the default operand width.
package restoring_divider_4_bit_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      STATE_IDLE   = 2'd0,
      STATE_RUN    = 2'd1,
      STATE_FINISH = 2'd2
   } state_t;

endpackage

// File: rtl/restoring_divider_4_bit_subtractor.sv
// Combinational ripple-borrow subtractor: DIFF = A - B - B_in, built as a
// chain of full subtractors; B_out is the borrow out of the top bit.
module ripple_borrow_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             B_in,
   output logic [WIDTH-1:0] DIFF,
   output logic             B_out
);

   logic [WIDTH:0] borrow;

   assign borrow[0] = B_in;

   // Each stage borrows when its minuend bit cannot cover subtrahend plus incoming borrow.
   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      assign DIFF[i]     = A[i] ^ B[i] ^ borrow[i];
      assign borrow[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & borrow[i]);
   end

   assign B_out = borrow[WIDTH];

endmodule

// File: rtl/restoring_divider_4_bit.sv
// Sequential unsigned restoring divider producing one quotient bit per clock,
// with a start/done handshake and a sticky divide-by-zero result flag.
module restoring_divider_4_bit
   import restoring_divider_4_bit_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] DIVIDEND,
   input  logic [WIDTH-1:0] DIVISOR,
   output logic [WIDTH-1:0] QUOTIENT,
   output logic [WIDTH-1:0] REMAINDER,
   output logic             busy,
   output logic             done,
   output logic             DIV_BY_ZERO
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   rem_reg;
   logic [WIDTH-1:0] quo_reg;
   logic [WIDTH-1:0] div_reg;
   logic [WIDTH:0]   shifted_rem;
   logic [WIDTH:0]   trial_diff;
   logic [WIDTH:0]   next_rem;
   logic [WIDTH-1:0] next_quo;
   logic             trial_borrow;
   logic             accept;
   logic             last_iter;

   // {R,Q} shifted left by one: the quotient MSB moves into the remainder LSB.
   assign shifted_rem = (rem_reg << 1) | {{WIDTH{1'b0}}, quo_reg[WIDTH-1]};

   ripple_borrow_subtractor #(
      .WIDTH (WIDTH + 1)
   ) u_trial_sub (
      .A     (shifted_rem),
      .B     ({1'b0, div_reg}),
      .B_in  (1'b0),
      .DIFF  (trial_diff),
      .B_out (trial_borrow)
   );

   assign next_rem = trial_borrow ? shifted_rem : trial_diff;
   assign next_quo = {quo_reg[WIDTH-2:0], ~trial_borrow};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= STATE_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // FINISH accepts a new start exactly like IDLE, enabling back-to-back divisions.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      last_iter  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         STATE_IDLE, STATE_FINISH: begin
            done = (state == STATE_FINISH);
            if (start) begin
               accept     = 1'b1;
               next_state = (DIVISOR == '0) ? STATE_FINISH : STATE_RUN;
            end else begin
               next_state = STATE_IDLE;
            end
         end
         STATE_RUN: begin
            busy      = 1'b1;
            last_iter = (cnt == CNT_W'(WIDTH - 1));
            if (last_iter) begin
               next_state = STATE_FINISH;
            end
         end
         default: next_state = STATE_IDLE;
      endcase
   end

   // Results load only on the edge entering FINISH, so partial values never leak out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         rem_reg     <= '0;
         quo_reg     <= '0;
         div_reg     <= '0;
         QUOTIENT    <= '0;
         REMAINDER   <= '0;
         DIV_BY_ZERO <= 1'b0;
      end else if (accept) begin
         cnt     <= '0;
         rem_reg <= '0;
         quo_reg <= DIVIDEND;
         div_reg <= DIVISOR;
         if (DIVISOR == '0) begin
            QUOTIENT    <= '1;
            REMAINDER   <= DIVIDEND;
            DIV_BY_ZERO <= 1'b1;
         end
      end else if (state == STATE_RUN) begin
         cnt     <= cnt + CNT_W'(1);
         rem_reg <= next_rem;
         quo_reg <= next_quo;
         if (last_iter) begin
            QUOTIENT    <= next_quo;
            REMAINDER   <= next_rem[WIDTH-1:0];
            DIV_BY_ZERO <= 1'b0;
         end
      end
   end

endmodule

// File: doc/restoring_divider_4_bit.md
Name: restoring_divider_4_bit

Overview:
- Sequential unsigned integer divider. It computes QUOTIENT = DIVIDEND / DIVISOR and REMAINDER = DIVIDEND % DIVISOR by restoring long division, one quotient bit per clock.
- It is the inverse arithmetic path of the team's ripple-carry adders and is built on a ripple-borrow subtractor datapath.
- It sits beside the 4-bit adder in the arithmetic library and is driven by a simple start/done handshake.

Parameters:
- WIDTH, 4, operand and result width in bits; the supported range is 2 to 16.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on a rising edge while not busy.
- DIVIDEND  input  WIDTH  unsigned dividend; captured when start is accepted.
- DIVISOR  input  WIDTH  unsigned divisor; captured when start is accepted.
- QUOTIENT  output  WIDTH  registered quotient; valid from the done cycle and held until the next result.
- REMAINDER  output  WIDTH  registered remainder; same validity as QUOTIENT.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse marking a new valid result.
- DIV_BY_ZERO  output  1  flag for the current result; high when the divisor was 0.

Behaviour:
- Reset (asynchronous, any time, including mid-division):
  - State goes to IDLE.
  - QUOTIENT, REMAINDER, busy, done and DIV_BY_ZERO all go to 0.
  - The iteration counter and internal registers are cleared.
  - No partial result is ever exposed.
- FSM states: IDLE, RUN, FINISH.
  - IDLE: busy=0. If start=1 on an edge, capture operands.
    - DIVISOR != 0: go to RUN with cnt=0, partial remainder R=0 (WIDTH+1 bits), Q=DIVIDEND.
    - DIVISOR == 0: go to FINISH directly.
  - RUN: busy=1. Each edge does one iteration:
    - Shift {R,Q} left by 1.
    - Trial difference T = R - {0,D} via the subtractor.
    - If no borrow: R=T and Q[0]=1. Otherwise R is kept (restored) and Q[0]=0.
    - cnt increments. On the edge that completes iteration WIDTH, go to FINISH.
  - FINISH: done=1 and busy=0 for exactly one cycle.
    - QUOTIENT, REMAINDER and DIV_BY_ZERO load on the edge entering FINISH, so they are visible in the same cycle done=1.
    - FINISH behaves as IDLE for start: start=1 here is accepted (back-to-back operation). Otherwise return to IDLE.
- Latency:
  - Normal division: start accepted on edge E0; done=1 in the cycle after edge E(WIDTH). That is WIDTH+1 edges, so E4 for WIDTH=4.
  - Divide by zero: done=1 in the cycle after E0.
- Divide by zero result: QUOTIENT = all ones (2^WIDTH-1), REMAINDER = DIVIDEND, DIV_BY_ZERO=1.
- Flag handling: DIV_BY_ZERO is cleared when the next result loads. It is held with the result, not pulsed.
- start while busy=1 (RUN) is ignored. Operands are not recaptured and the running division is unaffected.
- Operand changes after capture have no effect on the running division.
- Outputs hold their last result through IDLE and RUN until the next FINISH.
- Width rules:
  - The partial remainder is WIDTH+1 bits, so the shifted remainder never overflows.
  - The final REMAINDER is R[WIDTH-1:0]. The invariant R < DIVISOR guarantees R[WIDTH]=0.
  - Arithmetic is unsigned only.
- The counter is ceil(log2(WIDTH+1)) bits wide and never wraps during valid operation.

Decomposition:
- Shared header/package:
  - FSM state encodings STATE_IDLE=2'd0, STATE_RUN=2'd1, STATE_FINISH=2'd2.
  - Default WIDTH constant.
- Sub-module: ripple_borrow_subtractor.
  - Parameterised width.
  - Outputs DIFF and B_out; inputs A, B and B_in.
  - Built from chained full subtractors, mirroring the team's full-adder chain.
  - Purely combinational; instantiated once at WIDTH+1 bits for the trial subtraction.

Test Plan:
1. WIDTH=4, DIVIDEND=7, DIVISOR=2, start pulse -> busy=1 for 4 cycles; done=1 one cycle after E4 with QUOTIENT=3, REMAINDER=1, DIV_BY_ZERO=0.
2. Boundary operands: 15/1 -> Q=15, R=0; 3/5 -> Q=0, R=3; 15/15 -> Q=1, R=0; 0/7 -> Q=0, R=0. Each has done exactly one cycle after E4.
3. DIVIDEND=9, DIVISOR=0 -> done=1 in the cycle after E0, QUOTIENT=15, REMAINDER=9, DIV_BY_ZERO=1. A following 6/3 gives Q=2, R=0, DIV_BY_ZERO=0.
4. 13/4 started; start reasserted with 1/1 during RUN -> ignored; result Q=3, R=1. Outputs stay stable until the next done.
5. Back-to-back: start held high across the done cycle with 14/3 then 8/2 -> first done gives Q=4, R=2; the second done follows WIDTH+1 edges later with Q=4, R=0.
6. rst asserted asynchronously mid-RUN (between clock edges) -> all outputs 0 immediately. After release with no start, done never pulses. A new 10/3 then gives Q=3, R=1.
